axi2mem_trans_unit_nlane: RTL and testbench
===========================================

Name: axi2mem_trans_unit_nlane

Overview:
Parametrised read/write data transfer buffer between the AXI-side datapath (one wide beat) and NB_LANES independent 32-bit TCDM lanes.
- Read side: gathers per-lane TCDM read responses plus beat metadata (ID, last) into full-width beats.
- Write side: scatters wide write beats and strobes into per-lane queues, skipping lanes whose strobe is all-zero.
- Sits between the axi2mem read/write control units and the TCDM request/response lanes.

Parameters:
NB_LANES, 2, number of 32-bit TCDM lanes; ext width = 32*NB_LANES, must be >=1
LD_BUFFER_SIZE, 2, entries per read lane FIFO and read meta FIFO, >=1, need not be a power of two
ST_BUFFER_SIZE, 2, entries per write lane FIFO, >=1
ID_WIDTH, 6, AXI ID width carried with read beats
CNT_W, $clog2(max(LD,ST)+1), occupancy counter width (derived, not overridable)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
rd_data_push_dat_i  in  NB_LANES*32  per-lane TCDM read data, lane k = bits [32k+31:32k]
rd_data_push_req_i  in  NB_LANES  per-lane push request
rd_data_push_gnt_o  out  NB_LANES  per-lane push grant (= lane FIFO not full)
rd_data_push_id_i  in  ID_WIDTH  beat ID, captured with lane 0 push
rd_data_push_last_i  in  1  beat last flag, captured with lane 0 push
rd_data_pop_dat_o  out  NB_LANES*32  assembled beat at heads of lane FIFOs
rd_data_pop_req_i  in  1  pop request from AXI R channel
rd_data_pop_gnt_o  out  1  beat available
rd_data_pop_id_o  out  ID_WIDTH  head meta ID
rd_data_pop_last_o  out  1  head meta last
wr_data_push_dat_i  in  NB_LANES*32  AXI W data
wr_data_push_strb_i  in  NB_LANES*4  AXI W strobes
wr_data_push_req_i  in  1  push request
wr_data_push_gnt_o  out  1  all write lane FIFOs not full
wr_data_pop_dat_o  out  NB_LANES*32  per-lane head data
wr_data_pop_strb_o  out  NB_LANES*4  per-lane head strobe
wr_data_pop_req_i  in  NB_LANES  per-lane pop request
wr_data_pop_gnt_o  out  NB_LANES  per-lane FIFO not empty
rd_usage_o  out  CNT_W  read meta FIFO occupancy
wr_usage_o  out  NB_LANES*CNT_W  per-lane write FIFO occupancy

Behaviour:
- FIFO implementation: all FIFOs are in-module circular buffers, no fall-through.
  - Pointers wrap from DEPTH-1 to 0; occupancy counters run 0..DEPTH.
  - Head entry is driven directly from storage at the read pointer.
- Handshakes: a push/pop takes effect only on req & gnt in the same cycle. Requests without grant are ignored and never corrupt state, i.e. overflow/underflow is impossible.
- Grants are combinational from counters only; no req-to-gnt paths.
- Read lanes:
  - rd_data_push_gnt_o[k] = (cnt_k != LD_BUFFER_SIZE). Push when full is refused even if a pop occurs in the same cycle.
  - Meta FIFO {id,last} pushes exactly on a lane-0 accepted push, so meta count always equals lane-0 count.
  - rd_data_pop_gnt_o = all read lane counts != 0 AND meta count != 0.
  - On an accepted pop, every read lane FIFO and the meta FIFO pop together.
  - Lanes fill independently and may be skewed; a lane ahead of others only blocks on its own full condition.
- Write lanes:
  - wr_data_push_gnt_o = all write lane counts != ST_BUFFER_SIZE, regardless of strobe.
  - On an accepted push, lane k stores {strb_k, dat_k} only if strb_k != 4'h0; all-zero-strobe lanes are skipped.
  - If every strobe is zero, the beat is accepted and nothing is stored.
  - wr_data_pop_gnt_o[k] = cnt_k != 0. Each lane pops independently on wr_data_pop_req_i[k] & gnt[k].
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
  - When empty, push is accepted and pop is refused (count becomes 1).
  - When full, pop is accepted and push is refused (count becomes DEPTH-1).
- Latency: data pushed in cycle N is visible at the head and grants assert in cycle N+1 at the earliest.
- Reset (rst_i high at a clock edge) applies mid-operation too; all pointers, counts and storage are cleared. Values in the cycle after reset:
  - rd_data_push_gnt_o all 1; wr_data_push_gnt_o 1
  - rd_data_pop_gnt_o 0; wr_data_pop_gnt_o all 0
  - All data/strb/id/last outputs 0; usage outputs 0
  - In-flight beats are discarded; requests during reset are ignored.
- Usage outputs are the registered counts, updated the cycle after a handshake.

Test Plan:
- NB_LANES=2, LD=2: push lane0 0x11 (id=5, last=0) and lane1 0x22 in cycle 0, pop in cycle 2 -> cycle 1 gnt=1, dat=0x00000022_00000011, id=5, last=0; cycle 3 gnt=0, rd_usage_o=0.
- Skew: lane0 pushes 2 entries, lane1 pushes none -> rd_data_push_gnt_o=2'b10, rd_data_pop_gnt_o=0. A lane1 push then raises pop gnt the next cycle with lane0's first entry at the head.
- Write push 0xAAAA_BBBB_CCCC_DDDD, strb=8'hF0 -> only lane1 stores 0xAAAABBBB/4'hF; wr_data_pop_gnt_o=2'b10, wr_usage_o lane0=0, lane1=1.
- Fill a write lane to ST=2, then drive push and pop in the same cycle -> push refused, count goes 2->1. Next cycle push accepted, count back to 2.
- Wrap-around with LD=3: 7 back-to-back read beats with continuous pop -> IDs emerge in order 0..6, last flags preserved, no grant glitch.
- Assert rst_i for 1 cycle with 2 beats queued each side -> all pop grants 0, push grants 1, outputs 0. A stale pop request in the following cycle has no effect.

Source files
------------

// File: rtl/axi2mem_trans_unit_nlane.sv
// Read/write transfer buffer between one wide AXI beat and NB_LANES 32-bit TCDM lanes.
// Read lanes gather into full beats with {id,last} metadata; write beats scatter per lane by strobe.
module axi2mem_trans_unit_nlane #(
   parameter int NB_LANES       = 2,
   parameter int LD_BUFFER_SIZE = 2,
   parameter int ST_BUFFER_SIZE = 2,
   parameter int ID_WIDTH       = 6,
   localparam int MAX_DEPTH     = (LD_BUFFER_SIZE > ST_BUFFER_SIZE) ? LD_BUFFER_SIZE : ST_BUFFER_SIZE,
   localparam int CNT_W         = $clog2(MAX_DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_LANES*32-1:0]    rd_data_push_dat_i,
   input  logic [NB_LANES-1:0]       rd_data_push_req_i,
   output logic [NB_LANES-1:0]       rd_data_push_gnt_o,
   input  logic [ID_WIDTH-1:0]       rd_data_push_id_i,
   input  logic                      rd_data_push_last_i,
   output logic [NB_LANES*32-1:0]    rd_data_pop_dat_o,
   input  logic                      rd_data_pop_req_i,
   output logic                      rd_data_pop_gnt_o,
   output logic [ID_WIDTH-1:0]       rd_data_pop_id_o,
   output logic                      rd_data_pop_last_o,
   input  logic [NB_LANES*32-1:0]    wr_data_push_dat_i,
   input  logic [NB_LANES*4-1:0]     wr_data_push_strb_i,
   input  logic                      wr_data_push_req_i,
   output logic                      wr_data_push_gnt_o,
   output logic [NB_LANES*32-1:0]    wr_data_pop_dat_o,
   output logic [NB_LANES*4-1:0]     wr_data_pop_strb_o,
   input  logic [NB_LANES-1:0]       wr_data_pop_req_i,
   output logic [NB_LANES-1:0]       wr_data_pop_gnt_o,
   output logic [CNT_W-1:0]          rd_usage_o,
   output logic [NB_LANES*CNT_W-1:0] wr_usage_o
);

   localparam int LD_PW = (LD_BUFFER_SIZE > 1) ? $clog2(LD_BUFFER_SIZE) : 1;
   localparam int ST_PW = (ST_BUFFER_SIZE > 1) ? $clog2(ST_BUFFER_SIZE) : 1;
   localparam logic [CNT_W-1:0] LD_FULL = CNT_W'(LD_BUFFER_SIZE);
   localparam logic [CNT_W-1:0] ST_FULL = CNT_W'(ST_BUFFER_SIZE);
   localparam logic [LD_PW-1:0] LD_LAST = LD_PW'(LD_BUFFER_SIZE - 1);
   localparam logic [ST_PW-1:0] ST_LAST = ST_PW'(ST_BUFFER_SIZE - 1);

   logic [NB_LANES-1:0] rd_lane_nempty;
   logic [NB_LANES-1:0] rd_lane_push;
   logic [NB_LANES-1:0] wr_lane_nfull;
   logic                rd_pop;
   logic                wr_push;

   logic [ID_WIDTH:0]   meta_mem [LD_BUFFER_SIZE];
   logic [LD_PW-1:0]    meta_wptr;
   logic [LD_PW-1:0]    meta_rptr;
   logic [CNT_W-1:0]    meta_cnt;

   assign rd_data_pop_gnt_o  = (&rd_lane_nempty) && (meta_cnt != '0);
   assign rd_pop             = rd_data_pop_req_i & rd_data_pop_gnt_o;
   assign wr_data_push_gnt_o = &wr_lane_nfull;
   assign wr_push            = wr_data_push_req_i & wr_data_push_gnt_o;
   assign rd_usage_o         = meta_cnt;
   assign {rd_data_pop_id_o, rd_data_pop_last_o} = meta_mem[meta_rptr];

   // Meta entries follow lane 0 so the beat header stays aligned with lane 0 data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_wptr <= '0;
         meta_rptr <= '0;
         meta_cnt  <= '0;
         for (int unsigned i = 0; i < LD_BUFFER_SIZE; i++) meta_mem[LD_PW'(i)] <= '0;
      end else begin
         if (rd_lane_push[0]) begin
            meta_mem[meta_wptr] <= {rd_data_push_id_i, rd_data_push_last_i};
            meta_wptr <= (meta_wptr == LD_LAST) ? '0 : meta_wptr + 1'b1;
         end
         if (rd_pop) meta_rptr <= (meta_rptr == LD_LAST) ? '0 : meta_rptr + 1'b1;
         if (rd_lane_push[0] && !rd_pop)      meta_cnt <= meta_cnt + 1'b1;
         else if (!rd_lane_push[0] && rd_pop) meta_cnt <= meta_cnt - 1'b1;
      end
   end

   for (genvar k = 0; k < NB_LANES; k++) begin : g_rd_lane
      logic [31:0]      mem [LD_BUFFER_SIZE];
      logic [LD_PW-1:0] wptr;
      logic [LD_PW-1:0] rptr;
      logic [CNT_W-1:0] cnt;

      assign rd_data_push_gnt_o[k]         = (cnt != LD_FULL);
      assign rd_lane_push[k]               = rd_data_push_req_i[k] & rd_data_push_gnt_o[k];
      assign rd_lane_nempty[k]             = (cnt != '0);
      assign rd_data_pop_dat_o[32*k +: 32] = mem[rptr];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < LD_BUFFER_SIZE; i++) mem[LD_PW'(i)] <= '0;
         end else begin
            if (rd_lane_push[k]) begin
               mem[wptr] <= rd_data_push_dat_i[32*k +: 32];
               wptr <= (wptr == LD_LAST) ? '0 : wptr + 1'b1;
            end
            if (rd_pop) rptr <= (rptr == LD_LAST) ? '0 : rptr + 1'b1;
            if (rd_lane_push[k] && !rd_pop)      cnt <= cnt + 1'b1;
            else if (!rd_lane_push[k] && rd_pop) cnt <= cnt - 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NB_LANES; k++) begin : g_wr_lane
      logic [35:0]      mem [ST_BUFFER_SIZE];
      logic [ST_PW-1:0] wptr;
      logic [ST_PW-1:0] rptr;
      logic [CNT_W-1:0] cnt;
      logic             push;
      logic             pop;

      // Lanes with an all-zero strobe have nothing to write and are skipped.
      assign push                     = wr_push & (|wr_data_push_strb_i[4*k +: 4]);
      assign pop                      = wr_data_pop_req_i[k] & wr_data_pop_gnt_o[k];
      assign wr_data_pop_gnt_o[k]     = (cnt != '0);
      assign wr_lane_nfull[k]         = (cnt != ST_FULL);
      assign wr_usage_o[CNT_W*k +: CNT_W] = cnt;
      assign {wr_data_pop_strb_o[4*k +: 4], wr_data_pop_dat_o[32*k +: 32]} = mem[rptr];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < ST_BUFFER_SIZE; i++) mem[ST_PW'(i)] <= '0;
         end else begin
            if (push) begin
               mem[wptr] <= {wr_data_push_strb_i[4*k +: 4], wr_data_push_dat_i[32*k +: 32]};
               wptr <= (wptr == ST_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= (rptr == ST_LAST) ? '0 : rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (!push && pop) cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi2mem_trans_unit_nlane.sv
// Self-checking bench: queue-based scoreboard per lane against the NB_LANES=2 buffer,
// plus an LD=3 instance exercising pointer wrap-around on the read side.
module tb_axi2mem_trans_unit_nlane;
   localparam int NL  = 2;
   localparam int LD  = 2;
   localparam int ST  = 2;
   localparam int LD3 = 3;
   localparam int IDW = 6;
   localparam int CW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NL*32-1:0] rd_push_dat, rd_pop_dat, wr_push_dat, wr_pop_dat;
   logic [NL-1:0]    rd_push_req, rd_push_gnt, wr_pop_req, wr_pop_gnt;
   logic [IDW-1:0]   rd_push_id, rd_pop_id;
   logic             rd_push_last, rd_pop_req, rd_pop_gnt, rd_pop_last;
   logic [NL*4-1:0]  wr_push_strb, wr_pop_strb;
   logic             wr_push_req, wr_push_gnt;
   logic [CW-1:0]    rd_usage;
   logic [NL*CW-1:0] wr_usage;

   logic [NL*32-1:0] rd_push_dat3, rd_pop_dat3, wr_push_dat3, wr_pop_dat3;
   logic [NL-1:0]    rd_push_req3, rd_push_gnt3, wr_pop_req3, wr_pop_gnt3;
   logic [IDW-1:0]   rd_push_id3, rd_pop_id3;
   logic             rd_push_last3, rd_pop_req3, rd_pop_gnt3, rd_pop_last3;
   logic [NL*4-1:0]  wr_push_strb3, wr_pop_strb3;
   logic             wr_push_req3, wr_push_gnt3;
   logic [CW-1:0]    rd_usage3;
   logic [NL*CW-1:0] wr_usage3;

   axi2mem_trans_unit_nlane #(.NB_LANES(NL), .LD_BUFFER_SIZE(LD), .ST_BUFFER_SIZE(ST), .ID_WIDTH(IDW)) dut (
      .clk_i(clk), .rst_i(rst),
      .rd_data_push_dat_i(rd_push_dat), .rd_data_push_req_i(rd_push_req), .rd_data_push_gnt_o(rd_push_gnt),
      .rd_data_push_id_i(rd_push_id), .rd_data_push_last_i(rd_push_last),
      .rd_data_pop_dat_o(rd_pop_dat), .rd_data_pop_req_i(rd_pop_req), .rd_data_pop_gnt_o(rd_pop_gnt),
      .rd_data_pop_id_o(rd_pop_id), .rd_data_pop_last_o(rd_pop_last),
      .wr_data_push_dat_i(wr_push_dat), .wr_data_push_strb_i(wr_push_strb), .wr_data_push_req_i(wr_push_req),
      .wr_data_push_gnt_o(wr_push_gnt), .wr_data_pop_dat_o(wr_pop_dat), .wr_data_pop_strb_o(wr_pop_strb),
      .wr_data_pop_req_i(wr_pop_req), .wr_data_pop_gnt_o(wr_pop_gnt),
      .rd_usage_o(rd_usage), .wr_usage_o(wr_usage));

   axi2mem_trans_unit_nlane #(.NB_LANES(NL), .LD_BUFFER_SIZE(LD3), .ST_BUFFER_SIZE(ST), .ID_WIDTH(IDW)) dut3 (
      .clk_i(clk), .rst_i(rst),
      .rd_data_push_dat_i(rd_push_dat3), .rd_data_push_req_i(rd_push_req3), .rd_data_push_gnt_o(rd_push_gnt3),
      .rd_data_push_id_i(rd_push_id3), .rd_data_push_last_i(rd_push_last3),
      .rd_data_pop_dat_o(rd_pop_dat3), .rd_data_pop_req_i(rd_pop_req3), .rd_data_pop_gnt_o(rd_pop_gnt3),
      .rd_data_pop_id_o(rd_pop_id3), .rd_data_pop_last_o(rd_pop_last3),
      .wr_data_push_dat_i(wr_push_dat3), .wr_data_push_strb_i(wr_push_strb3), .wr_data_push_req_i(wr_push_req3),
      .wr_data_push_gnt_o(wr_push_gnt3), .wr_data_pop_dat_o(wr_pop_dat3), .wr_data_pop_strb_o(wr_pop_strb3),
      .wr_data_pop_req_i(wr_pop_req3), .wr_data_pop_gnt_o(wr_pop_gnt3),
      .rd_usage_o(rd_usage3), .wr_usage_o(wr_usage3));

   int checks   = 0;
   int failures = 0;

   logic [31:0]    m_rl [NL][$];
   logic [IDW:0]   m_meta [$];
   logic [35:0]    m_wl [NL][$];
   logic [IDW+64:0] q3 [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd_push_dat = '0; rd_push_req = '0; rd_push_id = '0; rd_push_last = 1'b0; rd_pop_req = 1'b0;
      wr_push_dat = '0; wr_push_strb = '0; wr_push_req = 1'b0; wr_pop_req = '0;
      rd_push_dat3 = '0; rd_push_req3 = '0; rd_push_id3 = '0; rd_push_last3 = 1'b0; rd_pop_req3 = 1'b0;
      wr_push_dat3 = '0; wr_push_strb3 = '0; wr_push_req3 = 1'b0; wr_pop_req3 = '0;
   endtask

   // Compare every output of the main DUT against the scoreboard, then apply this cycle's handshakes.
   task automatic tick();
      logic [NL-1:0] e_rpg, e_wpopg;
      logic          e_popg, e_wpg;
      logic [IDW:0]  meta;
      logic [35:0]   wl;
      e_popg = (m_meta.size() != 0);
      e_wpg  = 1'b1;
      for (int unsigned k = 0; k < NL; k++) begin
         e_rpg[k]   = (m_rl[k].size() != LD);
         e_wpopg[k] = (m_wl[k].size() != 0);
         if (m_rl[k].size() == 0) e_popg = 1'b0;
         if (m_wl[k].size() == ST) e_wpg = 1'b0;
      end
      chk("rd_push_gnt", rd_push_gnt, e_rpg);
      chk("rd_pop_gnt", rd_pop_gnt, e_popg);
      chk("wr_push_gnt", wr_push_gnt, e_wpg);
      chk("wr_pop_gnt", wr_pop_gnt, e_wpopg);
      chk("rd_usage", rd_usage, m_meta.size());
      for (int unsigned k = 0; k < NL; k++) chk("wr_usage", wr_usage[CW*k +: CW], m_wl[k].size());
      if (e_popg) begin
         meta = m_meta[0];
         for (int unsigned k = 0; k < NL; k++) chk("rd_pop_dat", rd_pop_dat[32*k +: 32], m_rl[k][0]);
         chk("rd_pop_id", rd_pop_id, meta[IDW:1]);
         chk("rd_pop_last", rd_pop_last, meta[0]);
      end
      for (int unsigned k = 0; k < NL; k++) if (e_wpopg[k]) begin
         wl = m_wl[k][0];
         chk("wr_pop_dat", wr_pop_dat[32*k +: 32], wl[31:0]);
         chk("wr_pop_strb", wr_pop_strb[4*k +: 4], wl[35:32]);
      end
      if (rst) begin
         for (int unsigned k = 0; k < NL; k++) begin
            m_rl[k].delete();
            m_wl[k].delete();
         end
         m_meta.delete();
      end else begin
         if (rd_pop_req && e_popg) begin
            for (int unsigned k = 0; k < NL; k++) void'(m_rl[k].pop_front());
            void'(m_meta.pop_front());
         end
         for (int unsigned k = 0; k < NL; k++) if (rd_push_req[k] && e_rpg[k]) begin
            m_rl[k].push_back(rd_push_dat[32*k +: 32]);
            if (k == 0) m_meta.push_back({rd_push_id, rd_push_last});
         end
         for (int unsigned k = 0; k < NL; k++) begin
            if (wr_pop_req[k] && e_wpopg[k]) void'(m_wl[k].pop_front());
            if (wr_push_req && e_wpg && wr_push_strb[4*k +: 4] != 4'h0)
               m_wl[k].push_back({wr_push_strb[4*k +: 4], wr_push_dat[32*k +: 32]});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic tick3();
      logic          e_g, e_pg;
      logic [IDW+64:0] h;
      e_g  = (q3.size() != 0);
      e_pg = (q3.size() != LD3);
      chk("w3_pop_gnt", rd_pop_gnt3, e_g);
      chk("w3_push_gnt", rd_push_gnt3, {NL{e_pg}});
      chk("w3_usage", rd_usage3, q3.size());
      if (e_g) begin
         h = q3[0];
         chk("w3_dat", rd_pop_dat3, h[63:0]);
         chk("w3_last", rd_pop_last3, h[64]);
         chk("w3_id", rd_pop_id3, h[IDW+64:65]);
      end
      if (rd_pop_req3 && e_g) void'(q3.pop_front());
      if (&rd_push_req3 && e_pg) q3.push_back({rd_push_id3, rd_push_last3, rd_push_dat3});
      @(posedge clk); #1;
   endtask

   task automatic reset_chk(input string tag);
      chk({tag, "_rd_push_gnt"}, rd_push_gnt, 2'b11);
      chk({tag, "_wr_push_gnt"}, wr_push_gnt, 1'b1);
      chk({tag, "_rd_pop_gnt"}, rd_pop_gnt, 1'b0);
      chk({tag, "_wr_pop_gnt"}, wr_pop_gnt, 2'b00);
      chk({tag, "_rd_pop_dat"}, rd_pop_dat, 64'h0);
      chk({tag, "_rd_pop_id"}, rd_pop_id, 6'h0);
      chk({tag, "_rd_pop_last"}, rd_pop_last, 1'b0);
      chk({tag, "_wr_pop_dat"}, wr_pop_dat, 64'h0);
      chk({tag, "_wr_pop_strb"}, wr_pop_strb, 8'h0);
      chk({tag, "_rd_usage"}, rd_usage, 2'd0);
      chk({tag, "_wr_usage"}, wr_usage, 4'h0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      reset_chk("init");
      chk("init_w3_pop_gnt", rd_pop_gnt3, 1'b0);

      // single beat: both lanes pushed together, popped two cycles later
      rd_push_req = 2'b11; rd_push_dat = {32'h22, 32'h11}; rd_push_id = 6'd5; rd_push_last = 1'b0;
      tick(); idle();
      chk("t1_gnt", rd_pop_gnt, 1'b1);
      chk("t1_dat", rd_pop_dat, 64'h00000022_00000011);
      chk("t1_id", rd_pop_id, 6'd5);
      chk("t1_last", rd_pop_last, 1'b0);
      tick();
      rd_pop_req = 1'b1;
      tick(); idle();
      chk("t1_gnt_after", rd_pop_gnt, 1'b0);
      chk("t1_usage_after", rd_usage, 2'd0);

      // skewed lanes: lane 0 fills alone, its third push is refused
      rd_push_req = 2'b01; rd_push_dat = 64'hA0; rd_push_id = 6'd1; rd_push_last = 1'b0;
      tick();
      rd_push_dat = 64'hA1; rd_push_id = 6'd2; rd_push_last = 1'b1;
      tick(); idle();
      chk("skew_push_gnt", rd_push_gnt, 2'b10);
      chk("skew_pop_gnt", rd_pop_gnt, 1'b0);
      rd_push_req = 2'b01; rd_push_dat = 64'hA2; rd_push_id = 6'd9;
      tick(); idle();
      rd_push_req = 2'b10; rd_push_dat = {32'hB0, 32'h0};
      tick(); idle();
      chk("skew_pop_gnt_up", rd_pop_gnt, 1'b1);
      chk("skew_head", rd_pop_dat, {32'hB0, 32'hA0});
      chk("skew_id", rd_pop_id, 6'd1);
      rd_pop_req = 1'b1; rd_push_req = 2'b10; rd_push_dat = {32'hB1, 32'h0};
      tick(); idle();
      rd_pop_req = 1'b1;
      tick(); idle();
      tick();

      // write scatter with strobe-based lane skipping
      wr_push_req = 1'b1; wr_push_dat = 64'hAAAABBBB_CCCCDDDD; wr_push_strb = 8'hF0;
      tick(); idle();
      chk("wr_scatter_gnt", wr_pop_gnt, 2'b10);
      chk("wr_scatter_usage", wr_usage, {2'd1, 2'd0});
      chk("wr_scatter_dat", wr_pop_dat[63:32], 32'hAAAABBBB);
      chk("wr_scatter_strb", wr_pop_strb[7:4], 4'hF);
      wr_push_req = 1'b1; wr_push_dat = 64'hDEADBEEF_DEADBEEF; wr_push_strb = 8'h00;
      tick();
      wr_push_dat = 64'h11112222_33334444; wr_push_strb = 8'h0C;
      tick();
      wr_push_dat = 64'h55556666_77778888; wr_push_strb = 8'hFF;
      tick(); idle();
      chk("wr_full_gnt", wr_push_gnt, 1'b0);
      wr_push_req = 1'b1; wr_push_dat = 64'h99999999_99999999; wr_push_strb = 8'hFF; wr_pop_req = 2'b11;
      tick(); idle();
      chk("wr_full_pushpop_usage", wr_usage, {2'd1, 2'd1});
      wr_push_req = 1'b1; wr_push_dat = 64'h12345678_9ABCDEF0; wr_push_strb = 8'h3F;
      tick(); idle();
      chk("wr_refill_usage", wr_usage, {2'd2, 2'd2});

      // reset with beats queued on both sides; stale requests around it must be ignored
      rd_push_req = 2'b11; rd_push_dat = 64'h1_00000001; rd_push_id = 6'd7;
      tick();
      rd_push_dat = 64'h2_00000002; rd_push_id = 6'd8; rd_push_last = 1'b1;
      tick(); idle();
      chk("pre_rst_usage", rd_usage, 2'd2);
      rst = 1'b1; rd_push_req = 2'b11; wr_push_req = 1'b1; wr_push_strb = 8'hFF; rd_pop_req = 1'b1;
      tick(); idle();
      rst = 1'b0;
      reset_chk("rst");
      rd_pop_req = 1'b1; wr_pop_req = 2'b11;
      tick(); idle();
      chk("stale_pop_rd_usage", rd_usage, 2'd0);
      chk("stale_pop_wr_usage", wr_usage, 4'h0);

      // random traffic against the scoreboard
      for (int n = 0; n < 400; n++) begin
         rd_push_req  = 2'($urandom);
         rd_push_dat  = {$urandom, $urandom};
         rd_push_id   = 6'($urandom);
         rd_push_last = 1'($urandom);
         rd_pop_req   = 1'($urandom);
         wr_push_req  = 1'($urandom);
         wr_push_dat  = {$urandom, $urandom};
         wr_push_strb = {($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                         ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom)};
         wr_pop_req   = 2'($urandom);
         tick();
      end
      idle();
      tick();

      // LD=3 wrap-around: 7 back-to-back beats, continuous pop from cycle 2
      for (int c = 0; c < 11; c++) begin
         idle();
         if (c < 7) begin
            rd_push_req3  = 2'b11;
            rd_push_dat3  = {32'(c + 100), 32'(c)};
            rd_push_id3   = 6'(c);
            rd_push_last3 = (c % 3 == 2);
         end
         rd_pop_req3 = (c >= 2);
         tick3();
      end
      idle();
      chk("w3_drained_gnt", rd_pop_gnt3, 1'b0);
      chk("w3_drained_usage", rd_usage3, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
